gf_mult_feeder: RTL and testbench
=================================

// Module: gf_mult_feeder
// PURPOSE
//  Command front-end for the gf_mult GF(2^8) add/multiply unit (poly 0x11D). Buffers operand
//  commands in a small FIFO (valid/ready in), sequences gf_mult's trigger/PENDING protocol one
//  op at a time, captures the 8-bit result and returns it on a valid/ready response port, in order.
//  Sits directly upstream of gf_mult; gf_mult ports are wired 1:1 to the mult_* ports.
// PARAMETERS
//  DEPTH     4   command FIFO entries; power of 2, >=2
//  IO_WIDTH  8   operand/result width; fixed, matches gf_mult
// PORTS
//  clk_i             in   1              clock
//  rst_ni            in   1              reset, asynchronous, active-low
//  cmd_valid_i       in   1              command valid
//  cmd_ready_o       out  1              command ready (= FIFO not full)
//  cmd_a_i           in   8              operand A
//  cmd_b_i           in   8              operand B
//  cmd_op_i          in   1              0 = GF add (XOR), 1 = GF multiply
//  rsp_valid_o       out  1              response valid
//  rsp_ready_i       in   1              response ready
//  rsp_data_o        out  8              result
//  rsp_op_o          out  1              op of the returned command
//  mult_trigger_o    out  1              to gf_mult trigger_i
//  mult_op_a_o       out  8              to gf_mult op_a_i
//  mult_op_b_o       out  8              to gf_mult op_b_i
//  mult_op_select_o  out  1              to gf_mult op_select_i
//  mult_result_i     in   8              from gf_mult result_o
//  mult_status_i     in   status_e       from gf_mult status_o (gf_mult_pkg IDLE/PENDING)
//  fifo_level_o      out  $clog2(DEPTH)+1 entries currently in FIFO
//  busy_o            out  1              FSM not in S_IDLE or FIFO non-empty
//  err_o             out  1              sticky protocol error
//  err_clr_i         in   1              clears err_o (err_o set wins if same cycle)
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; FSM S_IDLE; operand regs 0; err_o 0. Reset mid-op drops
//   FIFO contents and any in-flight op; no response is produced for them.
//  FIFO: push on cmd_valid_i & cmd_ready_o; cmd_ready_o = (level != DEPTH), from registered level.
//   Pop only in S_IDLE (or S_RESP handshake, below) when level != 0; push+pop same cycle keeps level.
//   Pointers wrap modulo DEPTH.
//  mult_op_a/b/select_o driven from operand regs only; stable from S_TRIG through S_CAPT.
//  FSM:
//   S_IDLE : level!=0 -> pop head into operand regs, -> S_TRIG.
//   S_TRIG : mult_trigger_o=1 (this state only, exactly 1 cycle) -> S_WAIT.
//   S_WAIT : mult_status_i==PENDING -> S_CAPT; else set err_o, drop op, -> S_IDLE.
//   S_CAPT : mult_status_i must be IDLE (else set err_o); register mult_result_i -> rsp_data_o,
//            op -> rsp_op_o, set rsp_valid_o -> S_RESP.
//   S_RESP : hold rsp_* stable while !rsp_ready_i. On handshake: clear rsp_valid_o; if level!=0
//            pop and -> S_TRIG, else -> S_IDLE.
//  Latency: cmd accepted at edge t into empty FIFO/S_IDLE -> rsp_valid_o high after edge t+4.
//  Throughput: one op per 4 cycles with rsp_ready_i held high.
//  Result width: mult_result_i is already reduced to 8 bits; passed through unmodified.
//  Order: responses strictly in command order; no reordering, no drops except on err.
// TESTING
//  T1 mul a=0x02 b=0x80 op=1 -> rsp_data_o=0x1D, rsp_op_o=1, rsp_valid_o 4 edges after accept.
//  T2 add a=0x57 b=0x83 op=0 -> rsp_data_o=0xD4; mul a=0x80 b=0x80 back-to-back -> 0x13, in order.
//  T3 DEPTH=4, rsp_ready_i=0, 6 cmds offered -> 5 accepted, cmd_ready_o=0, fifo_level_o=4;
//     release rsp_ready_i -> 5 responses in order, level returns to 0, busy_o falls.
//  T4 mult_status_i forced IDLE -> err_o=1 one edge after S_WAIT, no response, FSM to S_IDLE;
//     err_clr_i pulse -> err_o=0.
//  T5 rst_ni low during S_WAIT with 3 queued -> all outputs 0 immediately, level=0, no rsp after.
//  T6 push while full with simultaneous pop in S_RESP -> no push accepted that cycle, level=DEPTH-1.

Source files
------------

// File: rtl/gf_mult_feeder.sv
// gf_mult_feeder: command FIFO and sequencer in front of the gf_mult GF(2^8) unit.
// Commands are queued, issued one at a time through gf_mult's trigger/PENDING
// handshake, and the results are returned in command order on a valid/ready port.
`timescale 1ns/1ps
module gf_mult_feeder #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IO_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [IO_WIDTH-1:0]      cmd_a_i,
  input  logic [IO_WIDTH-1:0]      cmd_b_i,
  input  logic                     cmd_op_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [IO_WIDTH-1:0]      rsp_data_o,
  output logic                     rsp_op_o,
  output logic                     mult_trigger_o,
  output logic [IO_WIDTH-1:0]      mult_op_a_o,
  output logic [IO_WIDTH-1:0]      mult_op_b_o,
  output logic                     mult_op_select_o,
  input  logic [IO_WIDTH-1:0]      mult_result_i,
  input  logic                     mult_status_i,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic                     busy_o,
  output logic                     err_o,
  input  logic                     err_clr_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned EW = 2 * IO_WIDTH + 1;

  // gf_mult status encoding (IDLE / PENDING)
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_CAPT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  status_e             status;

  logic [EW-1:0]       mem [DEPTH];
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic                ready_q;
  logic                push, pop;
  logic                capture, rsp_done, err_set;
  logic [EW-1:0]       head;

  logic [IO_WIDTH-1:0] op_a_q, op_b_q;
  logic                op_sel_q;
  logic [IO_WIDTH-1:0] rsp_data_q;
  logic                rsp_op_q, rsp_valid_q;
  logic                err_q;

  assign status = status_e'(mult_status_i);
  assign push   = cmd_valid_i & ready_q;
  assign head   = mem[rptr_q];

  // Next FIFO occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // FIFO storage; contents need no reset since level/pointers gate all reads
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr_q] <= {cmd_op_i, cmd_a_i, cmd_b_i};
    end
  end

  // FIFO pointers, level and registered ready (held low while in reset)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      level_q <= level_d;
      ready_q <= (level_d != LW'(DEPTH));
    end
  end

  // Sequencer state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next state and per-state control strobes
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = S_TRIG;
        end
      end
      S_TRIG: state_d = S_WAIT;
      S_WAIT: begin
        if (status == ST_PENDING) begin
          state_d = S_CAPT;
        end else begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CAPT: begin
        if (status != ST_IDLE) err_set = 1'b1;
        capture = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_done = 1'b1;
          // chain straight into the next op to sustain one op per 4 cycles
          if (level_q != '0) begin
            pop     = 1'b1;
            state_d = S_TRIG;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand registers loaded on pop; they alone drive the gf_mult operand ports
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sel_q <= 1'b0;
    end else if (pop) begin
      {op_sel_q, op_a_q, op_b_q} <= head;
    end
  end

  // Response holding register: captured in S_CAPT, released on handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_data_q  <= '0;
      rsp_op_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else if (capture) begin
      rsp_data_q  <= mult_result_i;
      rsp_op_q    <= op_sel_q;
      rsp_valid_q <= 1'b1;
    end else if (rsp_done) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Sticky protocol error; a new error outranks a clear in the same cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (err_clr_i) begin
      err_q <= 1'b0;
    end
  end

  assign cmd_ready_o      = ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_op_o         = rsp_op_q;
  assign mult_trigger_o   = (state_q == S_TRIG);
  assign mult_op_a_o      = op_a_q;
  assign mult_op_b_o      = op_b_q;
  assign mult_op_select_o = op_sel_q;
  assign fifo_level_o     = level_q;
  assign busy_o           = (state_q != S_IDLE) || (level_q != '0);
  assign err_o            = err_q;

endmodule

// File: tb/tb_gf_mult_feeder.sv
// Testbench for gf_mult_feeder: emulates gf_mult, scoreboards responses against
// a GF(2^8) arithmetic reference (poly 0x11D).
`timescale 1ns/1ps
module tb_gf_mult_feeder;

  localparam int DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [7:0] cmd_a_i = '0;
  logic [7:0] cmd_b_i = '0;
  logic       cmd_op_i = 1'b0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic [7:0] rsp_data_o;
  logic       rsp_op_o;
  logic       mult_trigger_o;
  logic [7:0] mult_op_a_o, mult_op_b_o;
  logic       mult_op_select_o;
  logic [7:0] mult_result_i;
  logic       mult_status_i;
  logic [2:0] fifo_level_o;
  logic       busy_o, err_o;
  logic       err_clr_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  gf_mult_feeder #(.DEPTH(DEPTH), .IO_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_op_i(cmd_op_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_op_o(rsp_op_o),
    .mult_trigger_o(mult_trigger_o), .mult_op_a_o(mult_op_a_o),
    .mult_op_b_o(mult_op_b_o), .mult_op_select_o(mult_op_select_o),
    .mult_result_i(mult_result_i), .mult_status_i(mult_status_i),
    .fifo_level_o(fifo_level_o), .busy_o(busy_o), .err_o(err_o),
    .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // GF(2^8) reference: XOR for add, carry-less product reduced by 0x11D for multiply
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b, input logic op);
    logic [15:0] p;
    p = '0;
    if (!op) return a ^ b;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  // gf_mult stand-in: PENDING for the cycle after trigger, result ready when back to IDLE
  logic force_idle = 1'b0;
  logic       gm_status;
  logic [7:0] gm_result;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gm_status <= 1'b0;
      gm_result <= '0;
    end else begin
      gm_status <= mult_trigger_o & ~force_idle;
      if (mult_trigger_o) gm_result <= gf_ref(mult_op_a_o, mult_op_b_o, mult_op_select_o);
    end
  end
  assign mult_status_i = gm_status;
  assign mult_result_i = gm_result;

  // Handshake monitors: expected entries from accepted commands, observed from responses
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];
  int unsigned got_cyc[$];
  int unsigned cyc = 0;
  always @(posedge clk_i) begin
    cyc++;
    if (rst_ni) begin
      if (cmd_valid_i && cmd_ready_o) exp_q.push_back({cmd_op_i, gf_ref(cmd_a_i, cmd_b_i, cmd_op_i)});
      if (rsp_valid_o && rsp_ready_i) begin
        got_q.push_back({rsp_op_o, rsp_data_o});
        got_cyc.push_back(cyc);
      end
    end
  end

  logic [33:0] all_outs;
  assign all_outs = {cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_op_o, mult_trigger_o,
                     mult_op_a_o, mult_op_b_o, mult_op_select_o, fifo_level_o, busy_o, err_o};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; force_idle = 1'b0; cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b0; err_clr_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  // Present one command from a negedge; returns at the negedge after acceptance
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic op,
                      input int budget, output bit acc);
    cmd_valid_i = 1'b1; cmd_a_i = a; cmd_b_i = b; cmd_op_i = op;
    acc = 1'b0;
    for (int i = 0; i < budget; i++) begin
      acc = cmd_ready_o;
      @(negedge clk_i);
      if (acc) break;
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (cmd_ready_o !== 1'b1 || fifo_level_o !== 3'd0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: ready=%b level=%0d busy=%b expected 1 0 0",
                         cmd_ready_o, fifo_level_o, busy_o);
    end
  endtask

  task automatic test_latency();
    bit acc;
    do_reset();
    send(8'h02, 8'h80, 1'b1, 4, acc);
    n_checks++;
    if (!acc || rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL t1_accept: acc=%b rsp_valid=%b expected 1 0", acc, rsp_valid_o);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      n_checks++;
      if (mult_trigger_o !== (k == 1) || rsp_valid_o !== (k == 4)) begin
        n_fail++; $display("FAIL t1_timing edge+%0d: trig=%b valid=%b expected %b %b",
                           k, mult_trigger_o, rsp_valid_o, k == 1, k == 4);
      end
      if (k <= 3) begin
        n_checks++;
        if ({mult_op_select_o, mult_op_a_o, mult_op_b_o} !== {1'b1, 8'h02, 8'h80}) begin
          n_fail++; $display("FAIL t1_operands edge+%0d: got %b/%h/%h expected 1/02/80",
                             k, mult_op_select_o, mult_op_a_o, mult_op_b_o);
        end
      end
    end
    n_checks++;
    if (rsp_data_o !== 8'h1D || rsp_op_o !== 1'b1) begin
      n_fail++; $display("FAIL t1_result: got %h op %b expected 1d op 1", rsp_data_o, rsp_op_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== 8'h1D) begin
      n_fail++; $display("FAIL t1_hold: valid=%b data=%h expected 1 1d", rsp_valid_o, rsp_data_o);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    n_checks++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || got_q.size() != 1) begin
      n_fail++; $display("FAIL t1_handshake: valid=%b busy=%b nrsp=%0d expected 0 0 1",
                         rsp_valid_o, busy_o, got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int t;
    do_reset();
    rsp_ready_i = 1'b1;
    send(8'h57, 8'h83, 1'b0, 4, acc);
    send(8'h80, 8'h80, 1'b1, 4, acc);
    t = 0;
    while (got_q.size() < 2 && t < 40) begin @(negedge clk_i); t++; end
    rsp_ready_i = 1'b0;
    n_checks++;
    if (got_q.size() != 2) begin
      n_fail++; $display("FAIL t2_count: got %0d responses expected 2", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== {1'b0, 8'hD4} || got_q[1] !== {1'b1, 8'h13}) begin
        n_fail++; $display("FAIL t2_data: got %h,%h expected 0d4,113", got_q[0], got_q[1]);
      end
      n_checks++;
      if (got_cyc[1] - got_cyc[0] != 4) begin
        n_fail++; $display("FAIL t2_throughput: spacing %0d expected 4", got_cyc[1] - got_cyc[0]);
      end
    end
  endtask

  task automatic test_full();
    bit acc;
    int nacc, t;
    do_reset();
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), 6, acc);
      if (acc) nacc++;
    end
    n_checks++;
    if (nacc != 5 || exp_q.size() != 5 || cmd_ready_o !== 1'b0 || fifo_level_o !== 3'd4 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL t3_full: acc=%0d ready=%b level=%0d busy=%b expected 5 0 4 1",
                         nacc, cmd_ready_o, fifo_level_o, busy_o);
    end
    // full FIFO: a push offered alongside the S_RESP pop must be refused
    cmd_valid_i = 1'b1; cmd_a_i = 8'hAA; cmd_b_i = 8'h55; cmd_op_i = 1'b1;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0; rsp_ready_i = 1'b0;
    n_checks++;
    if (fifo_level_o !== 3'(DEPTH - 1) || exp_q.size() != 5 || got_q.size() != 1 || cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL t6_push_pop_full: level=%0d accepted=%0d rsp=%0d ready=%b expected 3 5 1 1",
                         fifo_level_o, exp_q.size(), got_q.size(), cmd_ready_o);
    end
    rsp_ready_i = 1'b1;
    t = 0;
    while (got_q.size() < 5 && t < 80) begin @(negedge clk_i); t++; end
    repeat (2) @(negedge clk_i);
    rsp_ready_i = 1'b0;
    n_checks++;
    if (got_q.size() != 5) begin
      n_fail++; $display("FAIL t3_drain_count: got %0d expected 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL t3_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (fifo_level_o !== 3'd0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL t3_drained: level=%0d busy=%b expected 0 0", fifo_level_o, busy_o);
    end
  endtask

  task automatic test_error();
    bit acc;
    do_reset();
    force_idle = 1'b1;
    rsp_ready_i = 1'b1;
    send(8'h12, 8'h34, 1'b1, 4, acc);
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL t4_err_early: got %b expected 0", err_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL t4_err_set: err=%b busy=%b expected 1 0", err_o, busy_o);
    end
    repeat (6) @(negedge clk_i);
    n_checks++;
    if (got_q.size() != 0 || rsp_valid_o !== 1'b0 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL t4_no_rsp: rsp=%0d valid=%b err=%b expected 0 0 1",
                         got_q.size(), rsp_valid_o, err_o);
    end
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL t4_err_clr: got %b expected 0", err_o);
    end
    force_idle = 1'b0;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit acc;
    int nrsp;
    do_reset();
    for (int i = 0; i < 5; i++) send(8'($urandom), 8'($urandom), 1'b1, 6, acc);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    nrsp = got_q.size();
    n_checks++;
    if (mult_trigger_o !== 1'b1 || fifo_level_o !== 3'd3) begin
      n_fail++; $display("FAIL t5_setup: trig=%b level=%0d expected 1 3", mult_trigger_o, fifo_level_o);
    end
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL t5_reset_outputs: got %h expected 0", all_outs);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    repeat (15) @(negedge clk_i);
    rsp_ready_i = 1'b0;
    n_checks++;
    if (got_q.size() != nrsp || fifo_level_o !== 3'd0 || busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL t5_dropped: rsp=%0d level=%0d busy=%b expected %0d 0 0",
                         got_q.size() - nrsp, fifo_level_o, busy_o, 0);
    end
  endtask

  task automatic test_random();
    bit acc, done;
    int nsent;
    do_reset();
    done = 1'b0;
    nsent = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk_i);
          send(8'($urandom), 8'($urandom), 1'($urandom), 60, acc);
          if (acc) nsent++;
        end
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 3000 && !(done && got_q.size() == exp_q.size()); c++) begin
          rsp_ready_i = ($urandom_range(0, 3) != 0);
          @(negedge clk_i);
        end
      end
    join
    rsp_ready_i = 1'b0;
    n_checks++;
    if (nsent != 40 || got_q.size() != 40 || exp_q.size() != 40) begin
      n_fail++; $display("FAIL rand_count: sent=%0d rsp=%0d exp=%0d expected 40", nsent, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_rsp[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL rand_end: err=%b busy=%b expected 0 0", err_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_full();
    test_error();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
